// File: rtl/serial_ripple_adder_if.sv
// Operand/result handshake bundle for serial_ripple_adder.
// The slave side is the adder; the master side is whoever feeds it and drains it.
interface serial_ripple_adder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] cout_int;
  logic                  overflow;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout_int, overflow
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout_int, overflow
  );
endinterface

// File: rtl/serial_ripple_adder.sv
// Multi-cycle ripple-carry adder/subtractor: one CHUNK_WIDTH slice per clock,
// carry held in a register between slices, valid/ready on both sides.
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready=1
// S_BUSY | rippling slice r_idx, partial sum/cout_int building up
// S_DONE | result held, out_valid=1 until out_ready
module serial_ripple_adder #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHUNK_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  serial_ripple_adder_if.slave  bus
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  generate
    if (DATA_WIDTH < 2 || CHUNK_WIDTH < 1 || CHUNK_WIDTH > DATA_WIDTH ||
        (DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_params
      $error("serial_ripple_adder: illegal DATA_WIDTH/CHUNK_WIDTH combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_in_ready;
  logic                  w_out_valid;

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_carry;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH:0]   r_sum;
  logic [DATA_WIDTH-1:0] r_cout;
  logic                  r_ovf;

  int                     w_base;
  logic [CHUNK_WIDTH-1:0] w_a_sl;
  logic [CHUNK_WIDTH-1:0] w_b_sl;
  logic [CHUNK_WIDTH-1:0] w_sum_sl;
  logic [CHUNK_WIDTH-1:0] w_cout_sl;
  logic                   w_ripple;
  logic [DATA_WIDTH-1:0]  w_sum_nxt;
  logic [DATA_WIDTH-1:0]  w_cout_nxt;
  logic                   w_last;

  assign w_last = (r_idx == LAST_IDX);

  // Slice datapath; r_b is already conditionally inverted, r_carry seeded with sub.
  always_comb begin
    w_base     = int'(r_idx) * CHUNK_WIDTH;
    w_a_sl     = r_a[w_base +: CHUNK_WIDTH];
    w_b_sl     = r_b[w_base +: CHUNK_WIDTH];
    w_sum_sl   = '0;
    w_cout_sl  = '0;
    w_ripple   = r_carry;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      w_sum_sl[i]  = w_a_sl[i] ^ w_b_sl[i] ^ w_ripple;
      w_cout_sl[i] = (w_a_sl[i] & w_b_sl[i]) | (w_ripple & (w_a_sl[i] ^ w_b_sl[i]));
      w_ripple     = w_cout_sl[i];
    end
    w_sum_nxt                         = r_sum[DATA_WIDTH-1:0];
    w_sum_nxt[w_base +: CHUNK_WIDTH]  = w_sum_sl;
    w_cout_nxt                        = r_cout;
    w_cout_nxt[w_base +: CHUNK_WIDTH] = w_cout_sl;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b ^ {DATA_WIDTH{bus.sub}};
            r_carry <= bus.sub;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= '0;
            r_ovf   <= 1'b0;
          end
        end
        S_BUSY: begin
          r_sum[DATA_WIDTH-1:0] <= w_sum_nxt;
          r_cout                <= w_cout_nxt;
          r_carry               <= w_ripple;
          if (w_last) begin
            r_sum[DATA_WIDTH] <= w_ripple;
            r_ovf             <= w_cout_nxt[DATA_WIDTH-1] ^ w_cout_nxt[DATA_WIDTH-2];
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout_int  = r_cout;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Directed bench: three adders (CW=2, 1, 8) share one input stream and are
// checked against hand-computed sums, carries, overflow and latency.
module tb_serial_ripple_adder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic       sub = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_ripple_adder_if #(.DATA_WIDTH(8)) if_c2 ();
  serial_ripple_adder_if #(.DATA_WIDTH(8)) if_c1 ();
  serial_ripple_adder_if #(.DATA_WIDTH(8)) if_c8 ();

  assign if_c2.in_valid = in_valid;  assign if_c1.in_valid = in_valid;  assign if_c8.in_valid = in_valid;
  assign if_c2.a = a;                assign if_c1.a = a;                assign if_c8.a = a;
  assign if_c2.b = b;                assign if_c1.b = b;                assign if_c8.b = b;
  assign if_c2.sub = sub;            assign if_c1.sub = sub;            assign if_c8.sub = sub;
  assign if_c2.out_ready = out_ready;
  assign if_c1.out_ready = out_ready;
  assign if_c8.out_ready = out_ready;

  serial_ripple_adder #(.DATA_WIDTH(8), .CHUNK_WIDTH(2)) u_dut_c2 (.clk(clk), .resetn(resetn), .bus(if_c2));
  serial_ripple_adder #(.DATA_WIDTH(8), .CHUNK_WIDTH(1)) u_dut_c1 (.clk(clk), .resetn(resetn), .bus(if_c1));
  serial_ripple_adder #(.DATA_WIDTH(8), .CHUNK_WIDTH(8)) u_dut_c8 (.clk(clk), .resetn(resetn), .bus(if_c8));

  logic       rdy [3];
  logic       vld [3];
  logic       ovf [3];
  logic [8:0] sm  [3];
  logic [7:0] co  [3];

  always_comb begin
    rdy[0] = if_c2.in_ready;  vld[0] = if_c2.out_valid;  ovf[0] = if_c2.overflow;
    sm[0]  = if_c2.sum;       co[0]  = if_c2.cout_int;
    rdy[1] = if_c1.in_ready;  vld[1] = if_c1.out_valid;  ovf[1] = if_c1.overflow;
    sm[1]  = if_c1.sum;       co[1]  = if_c1.cout_int;
    rdy[2] = if_c8.in_ready;  vld[2] = if_c8.out_valid;  ovf[2] = if_c8.overflow;
    sm[2]  = if_c8.sum;       co[2]  = if_c8.cout_int;
  end

  function automatic string name_of(input int j);
    case (j)
      0:       return "cw2";
      1:       return "cw1";
      default: return "cw8";
    endcase
  endfunction

  function automatic int lat_of(input int j);
    case (j)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on the falling edge right after the accept edge, with out_ready high.
  task automatic collect(input string tag, input logic [8:0] e_sum,
                         input logic [7:0] e_co, input logic e_ovf);
    logic       seen [3];
    int         lat  [3];
    logic [8:0] c_sm [3];
    logic [7:0] c_co [3];
    logic       c_ov [3];
    for (int j = 0; j < 3; j++) begin
      seen[j] = 1'b0; lat[j] = -1; c_sm[j] = '0; c_co[j] = '0; c_ov[j] = 1'b0;
      chk($sformatf("%s/%s in_ready_busy", tag, name_of(j)), 32'(rdy[j]), 32'd0);
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (vld[j] && !seen[j]) begin
          seen[j] = 1'b1; lat[j] = k;
          c_sm[j] = sm[j]; c_co[j] = co[j]; c_ov[j] = ovf[j];
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s/%s latency", tag, name_of(j)), 32'(lat[j]), 32'(lat_of(j)));
      chk($sformatf("%s/%s sum", tag, name_of(j)), 32'(c_sm[j]), 32'(e_sum));
      chk($sformatf("%s/%s cout_int", tag, name_of(j)), 32'(c_co[j]), 32'(e_co));
      chk($sformatf("%s/%s overflow", tag, name_of(j)), 32'(c_ov[j]), 32'(e_ovf));
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                       input logic op_sub, input logic [8:0] e_sum,
                       input logic [7:0] e_co, input logic e_ovf);
    @(negedge clk);
    in_valid = 1'b1; a = op_a; b = op_b; sub = op_sub; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    collect(tag, e_sum, e_co, e_ovf);
  endtask

  task automatic chk_idle(input string tag);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s/%s in_ready", tag, name_of(j)), 32'(rdy[j]), 32'd1);
      chk($sformatf("%s/%s out_valid", tag, name_of(j)), 32'(vld[j]), 32'd0);
      chk($sformatf("%s/%s sum", tag, name_of(j)), 32'(sm[j]), 32'd0);
      chk($sformatf("%s/%s cout_int", tag, name_of(j)), 32'(co[j]), 32'd0);
      chk($sformatf("%s/%s overflow", tag, name_of(j)), 32'(ovf[j]), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk_idle("reset");

    do_op("wrap",     8'hFF, 8'h01, 1'b0, 9'h100, 8'hFF, 1'b0);
    do_op("sovf",     8'h7F, 8'h01, 1'b0, 9'h080, 8'h7F, 1'b1);
    do_op("borrow",   8'h05, 8'h07, 1'b1, 9'h0FE, 8'h01, 1'b0);
    do_op("noborrow", 8'h07, 8'h05, 1'b1, 9'h102, 8'hFF, 1'b0);
    do_op("negovf",   8'h80, 8'h80, 1'b0, 9'h100, 8'h80, 1'b1);

    // Backpressure: result held while new operands wait on in_valid.
    @(negedge clk);
    in_valid = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!vld[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp/wait_valid", 32'(vld[0]), 32'd1);
    chk("bp/wait_cycles", 32'(k), 32'd4);
    in_valid = 1'b1; a = 8'h55; b = 8'h11; sub = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp/out_valid", 32'(vld[0]), 32'd1);
      chk("bp/in_ready", 32'(rdy[0]), 32'd0);
      chk("bp/sum", 32'(sm[0]), 32'h046);
      chk("bp/cout_int", 32'(co[0]), 32'h30);
      chk("bp/overflow", 32'(ovf[0]), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp/release_in_ready", 32'(rdy[0]), 32'd1);
    chk("bp/release_out_valid", 32'(vld[0]), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    collect("bp_new", 9'h144, 8'hFF, 1'b0);

    // Reset while CW=2 instance sits at slice index 2.
    @(negedge clk);
    in_valid = 1'b1; a = 8'h33; b = 8'h11; sub = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst/partial_sum", 32'(sm[0]), 32'h004);
    chk("rst/partial_cout", 32'(co[0]), 32'h03);
    resetn = 1'b0;
    #1;
    chk_idle("rst_mid");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk_idle("rst_release");
    do_op("fresh", 8'h10, 8'h20, 1'b0, 9'h030, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_ripple_adder.md
Name: serial_ripple_adder

Overview:
Multi-cycle, parametrised ripple-carry adder/subtractor. It processes one CHUNK_WIDTH slice of the operands per clock, holding the carry in a register between slices. Operands enter and results leave through valid/ready handshakes. The block is the sequential, area-reduced successor to the combinational ripple adder. It also exposes per-bit internal carries, add/subtract mode and signed overflow.

Parameters:
DATA_WIDTH, 8, operand width in bits; must be at least 2.
CHUNK_WIDTH, 2, bits added per cycle; must divide DATA_WIDTH; range 1..DATA_WIDTH.
NUM_CHUNKS, DATA_WIDTH/CHUNK_WIDTH, derived localparam; not overridable.

Ports:
clk  input  1  single clock, rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  DATA_WIDTH  operand A, unsigned or two's complement
b  input  DATA_WIDTH  operand B
sub  input  1  0: a+b; 1: a-b
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  DATA_WIDTH+1  result; bit DATA_WIDTH is the raw carry out (for sub: 1 = no borrow)
cout_int  output  DATA_WIDTH  cout_int[i] = carry out of bit i of the effective addition
overflow  output  1  signed overflow = cout_int[DATA_WIDTH-1] ^ cout_int[DATA_WIDTH-2]

Behaviour:
- Effective operation: a + (sub ? ~b : b) + sub. All arithmetic is modulo 2^DATA_WIDTH, plus the carry bit.
- Reset (async assert, sync deassert handled upstream): state=IDLE. Outputs: in_ready=1, out_valid=0, sum=0, cout_int=0, overflow=0. Internal carry, chunk index and operand registers are 0.
- FSM states and transitions:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid&&in_ready: capture a, b^{DATA_WIDTH{sub}} and carry=sub; clear index to 0; clear sum, cout_int and overflow to 0; go to BUSY.
  - BUSY:
    - in_ready=0. Each cycle, a CHUNK_WIDTH-bit ripple of full adders processes slice index.
    - Writes sum[index*CW +: CW] and cout_int[index*CW +: CW], and updates the carry register with the slice carry out.
    - index increments by 1.
    - On the cycle index==NUM_CHUNKS-1: also write sum[DATA_WIDTH]=final carry and overflow; go to DONE.
  - DONE:
    - out_valid=1, in_ready=0.
    - sum, cout_int and overflow are held stable.
    - On out_ready: go to IDLE (out_valid=0 next cycle).
- Latency: out_valid rises exactly NUM_CHUNKS cycles after the accept edge. Minimum issue interval is NUM_CHUNKS+2 cycles.
- in_valid is ignored outside IDLE; a, b and sub are sampled only on the accept edge.
- In BUSY, sum and cout_int contain partial results (completed slices; the rest are 0). They are only meaningful while out_valid=1.
- out_ready is ignored unless the state is DONE.
- CHUNK_WIDTH==DATA_WIDTH: NUM_CHUNKS=1, and the result is ready 1 cycle after accept.
- The index counter is $clog2(NUM_CHUNKS) bits wide, with a minimum of 1. It never wraps past NUM_CHUNKS-1.
- Reset asserted in any state, including mid-BUSY or DONE: immediate return to the reset values. The in-flight operation is discarded with no output.
- Illegal parameters (CHUNK_WIDTH not dividing DATA_WIDTH, or DATA_WIDTH<2) are rejected by an elaboration-time check.

Test Plan:
1. Reset: hold resetn=0, then release -> in_ready=1, out_valid=0, sum=0, cout_int=0, overflow=0.
2. Unsigned wrap, W=8, CW=2: a=0xFF, b=0x01, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x100, cout_int=0xFF, overflow=0.
3. Signed overflow: a=0x7F, b=0x01, sub=0 -> sum=0x080, cout_int=0x7F, overflow=1.
4. Subtract with borrow: a=0x05, b=0x07, sub=1 -> sum=0x0FE, cout_int=0x01, overflow=0. Then a=0x07, b=0x05, sub=1 -> sum=0x102, overflow=0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> outputs unchanged, in_ready=0, no new capture. Raise out_ready -> IDLE next cycle, then the new operands are accepted.
6. Reset mid-operation: assert resetn=0 at BUSY index 2 -> outputs zero immediately and in_ready=1 after release. A fresh add of 0x10+0x20 returns sum=0x030 with no residue. Repeat scenarios 2 and 3 with CW=1 (latency 8) and CW=8 (latency 1).
